// File: rtl/main_mem_pkg.sv
// Shared line geometry and responder state encoding for the main-memory interface.
package main_mem_pkg;

  localparam int unsigned LINE_BITS     = 512;
  localparam int unsigned WORD_BITS     = 32;
  localparam int unsigned OFFSET_BITS   = 6;
  localparam int unsigned WORD_SEL_BITS = 4;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] READ_WAIT  = 2'd1;
  localparam logic [1:0] WRITE_WAIT = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  // Base byte address of a line, used as its power-up fill pattern.
  function automatic logic [WORD_BITS-1:0] line_base(input int unsigned line);
    return WORD_BITS'(line << OFFSET_BITS);
  endfunction

endpackage

// File: rtl/main_mem_array.sv
// Line-wide synchronous read / word-granular write storage with a base-address fill pattern.
module main_mem_array
  import main_mem_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = 16,
  parameter int unsigned DEPTH_LINES = 256,
  localparam int unsigned IDX_BITS   = $clog2(DEPTH_LINES),
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     rd_zero,
  input  logic [IDX_BITS-1:0]      rd_idx,
  input  logic                     wr_en,
  input  logic [IDX_BITS-1:0]      wr_idx,
  input  logic [WORD_SEL_BITS-1:0] wr_sel,
  input  logic [WORD_BITS-1:0]     wr_data,
  output logic [LINE_W-1:0]        rd_line
);

  typedef logic [LINE_W-1:0] line_array_t [DEPTH_LINES];

  function automatic line_array_t init_lines();
    line_array_t a;
    for (int unsigned l = 0; l < DEPTH_LINES; l++) begin
      a[l] = {LINE_WORDS{line_base(l)}};
    end
    return a;
  endfunction

  // Power-up contents come from the declaration so block-RAM inference keeps them.
  logic [LINE_W-1:0] mem [DEPTH_LINES] = init_lines();

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx][32'(wr_sel) * WORD_BITS +: WORD_BITS] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_line <= '0;
    end else if (rd_en) begin
      rd_line <= rd_zero ? '0 : mem[rd_idx];
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory responder for the cache controller's request/ready interface.
// Optional bounds checking (err output, no wrap) is enabled by MAIN_MEM_BOUNDS_CHECK_EN.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = 16,
  parameter int unsigned DEPTH_LINES = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       main_mem_addr,
  input  logic [WORD_BITS-1:0]              main_mem_wdata,
  input  logic                              main_mem_read_req,
  input  logic                              main_mem_write_req,
  output logic [LINE_WORDS*WORD_BITS-1:0]   main_mem_rdata,
  output logic                              main_mem_ready,
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
  output logic                              main_mem_err,
`endif
  output logic                              main_mem_busy
);

  localparam int unsigned IDX_BITS = $clog2(DEPTH_LINES);
  localparam logic [3:0]  CNT_LAST = 4'(LATENCY - 1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d;
  logic                 last_cycle;
  logic                 oob;
  logic                 unused_addr_bits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        // Read has priority when both requests are raised together.
        if (main_mem_read_req) begin
          addr_d  = main_mem_addr;
          cnt_d   = '0;
          state_d = READ_WAIT;
        end else if (main_mem_write_req) begin
          addr_d  = main_mem_addr;
          wdata_d = main_mem_wdata;
          cnt_d   = '0;
          state_d = WRITE_WAIT;
        end
      end
      READ_WAIT, WRITE_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
  assign oob          = {6'b0, addr_q[31:OFFSET_BITS]} >= 32'(DEPTH_LINES);
  assign main_mem_err = (state_q == DONE) && oob;
`else
  assign oob = 1'b0;
`endif

  assign unused_addr_bits = ^{addr_q[1:0], addr_q[31:OFFSET_BITS+IDX_BITS]};

  assign last_cycle     = (cnt_q == CNT_LAST);
  assign main_mem_ready = (state_q == DONE);
  assign main_mem_busy  = (state_q != IDLE);

  main_mem_array #(
    .LINE_WORDS  (LINE_WORDS),
    .DEPTH_LINES (DEPTH_LINES)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   ((state_q == READ_WAIT) && last_cycle),
    .rd_zero (oob),
    .rd_idx  (addr_q[OFFSET_BITS +: IDX_BITS]),
    .wr_en   ((state_q == WRITE_WAIT) && last_cycle && !oob),
    .wr_idx  (addr_q[OFFSET_BITS +: IDX_BITS]),
    .wr_sel  (addr_q[2 +: WORD_SEL_BITS]),
    .wr_data (wdata_q),
    .rd_line (main_mem_rdata)
  );

endmodule
